// File: rtl/mmc_dat_wr_status.sv
// Write-path CRC status token and busy monitor on DAT0, started once the serialiser
// finishes a block; reports token, error flags and completion to the data-path controller.
module mmc_dat_wr_status #(
    parameter int START_TIMEOUT = 64,
    parameter int BUSY_TIMEOUT  = 65535
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       bitclk_i,
    input  logic       start_i,
    input  logic       abort_i,
    input  logic       dat_i,
    output logic       active_o,
    output logic       busy_o,
    output logic       complete_o,
    output logic [2:0] status_o,
    output logic       crc_err_o,
    output logic       write_err_o,
    output logic       framing_err_o,
    output logic       timeout_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_START,
        S_STATUS,
        S_END_BIT,
        S_BUSY,
        S_DONE
    } state_t;

    localparam logic [15:0] START_LAST = 16'(START_TIMEOUT - 1);
    localparam logic [15:0] BUSY_LAST  = 16'(BUSY_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        clk_q, clk_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  bit_cnt_q, bit_cnt_d;
    logic [2:0]  status_q, status_d;
    logic        crc_q, crc_d;
    logic        wr_q, wr_d;
    logic        fr_q, fr_d;
    logic        to_q, to_d;
    logic        sample_w;

    // Token decode into {crc_err, write_err, framing_err}.
    function automatic logic [2:0] decode_token(input logic [2:0] tok);
        case (tok)
            3'b010:  decode_token = 3'b000;
            3'b101:  decode_token = 3'b100;
            3'b110:  decode_token = 3'b010;
            default: decode_token = 3'b001;
        endcase
    endfunction

    // The serialiser drives on falling edges, so sample on the rising edge.
    assign sample_w = bitclk_i & ~clk_q;

    always_comb begin
        state_d   = state_q;
        clk_d     = bitclk_i;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        status_d  = status_q;
        crc_d     = crc_q;
        wr_d      = wr_q;
        fr_d      = fr_q;
        to_d      = to_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d   = S_WAIT_START;
                    cnt_d     = 16'd0;
                    bit_cnt_d = 2'd0;
                    status_d  = 3'b000;
                    crc_d     = 1'b0;
                    wr_d      = 1'b0;
                    fr_d      = 1'b0;
                    to_d      = 1'b0;
                end
            end
            S_WAIT_START: begin
                if (sample_w) begin
                    if (!dat_i) begin
                        state_d   = S_STATUS;
                        bit_cnt_d = 2'd0;
                    end else if (cnt_q == START_LAST) begin
                        to_d    = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            S_STATUS: begin
                if (sample_w) begin
                    status_d = {status_q[1:0], dat_i};
                    if (bit_cnt_q == 2'd2) begin
                        state_d = S_END_BIT;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 2'd1;
                    end
                end
            end
            S_END_BIT: begin
                if (sample_w) begin
                    {crc_d, wr_d, fr_d} = decode_token(status_q);
                    if (!dat_i) begin
                        fr_d = 1'b1;
                    end
                    state_d = S_BUSY;
                    cnt_d   = 16'd0;
                end
            end
            S_BUSY: begin
                if (sample_w) begin
                    if (dat_i) begin
                        state_d = S_DONE;
                    end else if (cnt_q == BUSY_LAST) begin
                        to_d    = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Abort wins over everything and leaves results and counters untouched.
        if (abort_i) begin
            state_d   = S_IDLE;
            cnt_d     = cnt_q;
            bit_cnt_d = bit_cnt_q;
            status_d  = status_q;
            crc_d     = crc_q;
            wr_d      = wr_q;
            fr_d      = fr_q;
            to_d      = to_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            clk_q     <= 1'b0;
            cnt_q     <= 16'd0;
            bit_cnt_q <= 2'd0;
            status_q  <= 3'b000;
            crc_q     <= 1'b0;
            wr_q      <= 1'b0;
            fr_q      <= 1'b0;
            to_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_q     <= clk_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            status_q  <= status_d;
            crc_q     <= crc_d;
            wr_q      <= wr_d;
            fr_q      <= fr_d;
            to_q      <= to_d;
        end
    end

    assign active_o      = (state_q != S_IDLE);
    assign busy_o        = (state_q == S_BUSY);
    assign complete_o    = (state_q == S_DONE);
    assign status_o      = status_q;
    assign crc_err_o     = crc_q;
    assign write_err_o   = wr_q;
    assign framing_err_o = fr_q;
    assign timeout_o     = to_q;

endmodule

// File: tb/tb_mmc_dat_wr_status.sv
// Directed bench for mmc_dat_wr_status: token decode, busy, timeouts, abort and reset.
module tb_mmc_dat_wr_status;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bitclk = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       dat = 1'b1;
    logic       active, busy, complete;
    logic [2:0] status;
    logic       crc_err, write_err, framing_err, timeout;

    int n_chk = 0;
    int n_pass = 0;
    int n_comp = 0;
    int comp_base;

    mmc_dat_wr_status #(.START_TIMEOUT(64), .BUSY_TIMEOUT(100)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bitclk_i(bitclk),
        .start_i(start),
        .abort_i(abort),
        .dat_i(dat),
        .active_o(active),
        .busy_o(busy),
        .complete_o(complete),
        .status_o(status),
        .crc_err_o(crc_err),
        .write_err_o(write_err),
        .framing_err_o(framing_err),
        .timeout_o(timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (complete) n_comp <= n_comp + 1;

    // {active, busy, complete, status[2:0], crc, write, framing, timeout}
    function automatic logic [9:0] vec();
        return {active, busy, complete, status, crc_err, write_err, framing_err, timeout};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One bit-clock period; returns at the negedge right after the sampling posedge.
    task automatic send_bit(input logic b);
        bitclk = 1'b0;
        dat    = b;
        @(negedge clk);
        @(negedge clk);
        bitclk = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_bits(input logic [4:0] bits);
        for (int i = 4; i >= 0; i--) send_bit(bits[i]);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_state", 32'(vec()), 32'(10'b0_0_0_000_0000));
        rst = 1'b0;
        @(negedge clk);

        // Good token 0 010 1, two busy lows, then release
        comp_base = n_comp;
        pulse_start();
        chk("good_active", 32'(active), 32'd1);
        send_bits(5'b00101);
        chk("good_after_end", 32'(vec()), 32'(10'b1_1_0_010_0000));
        send_bit(1'b0);
        chk("good_busy1", 32'(vec()), 32'(10'b1_1_0_010_0000));
        send_bit(1'b0);
        chk("good_busy2", 32'(vec()), 32'(10'b1_1_0_010_0000));
        send_bit(1'b1);
        chk("good_done", 32'(vec()), 32'(10'b1_0_1_010_0000));
        @(negedge clk);
        chk("good_idle", 32'(vec()), 32'(10'b0_0_0_010_0000));
        chk("good_one_pulse", 32'(n_comp - comp_base), 32'd1);

        // CRC error token, no busy period
        pulse_start();
        send_bits(5'b01011);
        send_bit(1'b1);
        chk("crc_done", 32'(vec()), 32'(10'b1_0_1_101_1000));

        // Write error token 110
        @(negedge clk);
        pulse_start();
        send_bits(5'b01101);
        send_bit(1'b1);
        chk("wr_done", 32'(vec()), 32'(10'b1_0_1_110_0100));

        // Good token with end bit 0 still proceeds to BUSY
        @(negedge clk);
        pulse_start();
        send_bits(5'b00100);
        chk("fr_end_busy", 32'(vec()), 32'(10'b1_1_0_010_0010));
        send_bit(1'b1);
        chk("fr_end_done", 32'(vec()), 32'(10'b1_0_1_010_0010));

        // Illegal token 111
        @(negedge clk);
        pulse_start();
        send_bits(5'b01111);
        send_bit(1'b1);
        chk("fr_111_done", 32'(vec()), 32'(10'b1_0_1_111_0010));

        // Start-bit timeout after exactly 64 high samples
        @(negedge clk);
        pulse_start();
        for (int i = 0; i < 63; i++) send_bit(1'b1);
        chk("sto_63", 32'(vec()), 32'(10'b1_0_0_000_0000));
        send_bit(1'b1);
        chk("sto_64", 32'(vec()), 32'(10'b1_0_1_000_0001));

        // Busy timeout after 100 low samples
        @(negedge clk);
        pulse_start();
        send_bits(5'b00101);
        for (int i = 0; i < 99; i++) send_bit(1'b0);
        chk("bto_99", 32'(vec()), 32'(10'b1_1_0_010_0000));
        send_bit(1'b0);
        chk("bto_100", 32'(vec()), 32'(10'b1_0_1_010_0001));

        // Abort in BUSY after a write-error token
        @(negedge clk);
        pulse_start();
        send_bits(5'b01101);
        send_bit(1'b0);
        chk("ab_in_busy", 32'(vec()), 32'(10'b1_1_0_110_0100));
        comp_base = n_comp;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("ab_idle", 32'(vec()), 32'(10'b0_0_0_110_0100));
        repeat (2) @(negedge clk);
        chk("ab_no_pulse", 32'(n_comp - comp_base), 32'd0);

        // Abort together with start in IDLE clears nothing
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        chk("ab_start_idle", 32'(vec()), 32'(10'b0_0_0_110_0100));

        // A fresh start clears stale results
        pulse_start();
        chk("restart_clear", 32'(vec()), 32'(10'b1_0_0_000_0000));
        send_bits(5'b00101);
        send_bit(1'b1);
        chk("restart_done", 32'(vec()), 32'(10'b1_0_1_010_0000));

        // Reset while in STATUS
        @(negedge clk);
        pulse_start();
        send_bit(1'b0);
        send_bit(1'b1);
        chk("rst_pre", 32'(vec()), 32'(10'b1_0_0_001_0000));
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid", 32'(vec()), 32'(10'b0_0_0_000_0000));
        rst = 1'b0;
        @(negedge clk);

        // Second start while in WAIT_START is ignored
        comp_base = n_comp;
        pulse_start();
        send_bit(1'b1);
        pulse_start();
        chk("start2_still_wait", 32'(vec()), 32'(10'b1_0_0_000_0000));
        send_bits(5'b00101);
        send_bit(1'b1);
        chk("start2_done", 32'(vec()), 32'(10'b1_0_1_010_0000));
        @(negedge clk);
        chk("start2_one_pulse", 32'(n_comp - comp_base), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
